affine_addr_checker: RTL

- Consumer-side counterpart to the 2D affine scan address generator (addr = x*x_stride + y*y_stride + offset, x fastest).
- Accepts an address stream over valid/ready and tracks its own (x, y) scan counters.
- Per address, emits the decoded (x, y) position, a match flag against the expected affine address, and a frame-done marker.
- Sits between an address source (generator or memory-port monitor) and downstream buffer/verification logic.

---
 rtl/affine_addr_checker.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/affine_addr_checker.sv
// ---------------------------------------------------------------------------
// affine_addr_checker
//
// Consumer-side checker for a 2D affine scan address stream
// (addr = x*x_stride + y*y_stride + offset, x fastest). It keeps its own
// (x, y) scan counters. For each accepted address it returns the decoded
// position, a match flag against the expected address and a frame-last
// marker. The result appears through a single-entry output register whose
// ready passes straight through to the input.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   offset               base address
//   x_max, y_max         inner / outer extents (0 behaves as 1)
//   x_stride, y_stride   inner / outer strides
//   clear                synchronous clear of counters, error state, out_valid
//   in_valid/in_ready    address input handshake, in_addr = observed address
//   out_valid/out_ready  result output handshake
//   out_x, out_y         decoded indices of the element
//   out_match            observed address equalled the expected one
//   out_last             element was the final one of the frame
//   err_count            (only with AFFINE_ADDR_CHECKER_ERRCNT_EN) saturating
//                        count of mismatching results
//   err_sticky           set on any mismatch until reset or clear
//
// Optional feature macro: AFFINE_ADDR_CHECKER_ERRCNT_EN
// ---------------------------------------------------------------------------
module affine_addr_checker #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  offset,
    input  logic [W-1:0]  x_max,
    input  logic [W-1:0]  x_stride,
    input  logic [W-1:0]  y_max,
    input  logic [W-1:0]  y_stride,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_x,
    output logic [W-1:0]  out_y,
    output logic          out_match,
    output logic          out_last,
`ifdef AFFINE_ADDR_CHECKER_ERRCNT_EN
    output logic [CW-1:0] err_count,
`endif
    output logic          err_sticky
);

    // Extent of 0 behaves as 1 so the counter always has at least one step.
    function automatic logic [W-1:0] clamp_extent(input logic [W-1:0] m);
        if (m == {W{1'b0}}) begin
            return W'(1);
        end else begin
            return m;
        end
    endfunction

    logic [W-1:0] x_cnt_q, x_cnt_d;
    logic [W-1:0] y_cnt_q, y_cnt_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_x_q, out_x_d;
    logic [W-1:0] out_y_q, out_y_d;
    logic         out_match_q, out_match_d;
    logic         out_last_q, out_last_d;
    logic         err_sticky_q, err_sticky_d;

    logic [W-1:0] xm_s, ym_s, exp_s;
    logic         x_wrap_s, y_wrap_s, accept_s, match_s;

    assign xm_s     = clamp_extent(x_max);
    assign ym_s     = clamp_extent(y_max);
    // >= rather than == so a counter stranded above a shrunk extent still wraps.
    assign x_wrap_s = (x_cnt_q >= (xm_s - W'(1)));
    assign y_wrap_s = (y_cnt_q >= (ym_s - W'(1)));
    assign exp_s    = (x_cnt_q * x_stride) + (y_cnt_q * y_stride) + offset;
    assign match_s  = (in_addr == exp_s);
    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Next-state: clear beats accept; accept loads a result and advances counters.
    always_comb begin
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_match_d  = out_match_q;
        out_last_d   = out_last_q;
        err_sticky_d = err_sticky_q;
        if (clear) begin
            x_cnt_d      = {W{1'b0}};
            y_cnt_d      = {W{1'b0}};
            out_valid_d  = 1'b0;
            err_sticky_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_x_d     = x_cnt_q;
            out_y_d     = y_cnt_q;
            out_match_d = match_s;
            out_last_d  = (x_cnt_q == (xm_s - W'(1))) && (y_cnt_q == (ym_s - W'(1)));
            if (!match_s) begin
                err_sticky_d = 1'b1;
            end else begin
                err_sticky_d = err_sticky_q;
            end
            if (x_wrap_s) begin
                x_cnt_d = {W{1'b0}};
                if (y_wrap_s) begin
                    y_cnt_d = {W{1'b0}};
                end else begin
                    y_cnt_d = y_cnt_q + W'(1);
                end
            end else begin
                x_cnt_d = x_cnt_q + W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q      <= {W{1'b0}};
            y_cnt_q      <= {W{1'b0}};
            out_valid_q  <= 1'b0;
            out_x_q      <= {W{1'b0}};
            out_y_q      <= {W{1'b0}};
            out_match_q  <= 1'b0;
            out_last_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_match_q  <= out_match_d;
            out_last_q   <= out_last_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_match  = out_match_q;
    assign out_last   = out_last_q;
    assign err_sticky = err_sticky_q;

`ifdef AFFINE_ADDR_CHECKER_ERRCNT_EN
    logic [CW-1:0] err_count_q, err_count_d;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            return v;
        end else begin
            return v + CW'(1);
        end
    endfunction

    // Mismatch counter next-state, zeroed by clear.
    always_comb begin
        err_count_d = err_count_q;
        if (clear) begin
            err_count_d = {CW{1'b0}};
        end else if (accept_s && !match_s) begin
            err_count_d = sat_inc(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Mismatch counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= {CW{1'b0}};
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
